huffman_packer: RTL and testbench
=================================

Name: huffman_packer

Overview:
Downstream stage of the Huffman coder. Consumes variable-length codes (1–10 bits) plus their lengths, and packs them MSB-first into a continuous bitstream. Emits that bitstream as 8-bit bytes over a valid/ready interface. Drives the coder's `load` input as its acknowledge, and supports an explicit flush that zero-pads the final partial byte.

Parameters:
MAX_CODE_LEN, 10, widest Huffman code accepted; sets code_in width; accumulator width = MAX_CODE_LEN+7
LEN_W, 4, width of code_len input

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
code_in  input  MAX_CODE_LEN  Huffman code, right-aligned; bit [code_len-1] is sent first
code_len  input  LEN_W  number of valid bits in code_in
code_valid  input  1  coder output valid (coder valid_out)
code_load  output  1  acknowledge pulse to coder `load` input
flush  input  1  single-cycle request to pad and emit the pending partial byte
byte_out  output  8  packed byte, first stream bit at bit 7
byte_valid  output  1  byte_out valid
byte_ready  input  1  downstream accepts byte when high with byte_valid
byte_last  output  1  qualifies byte_out as the padded flush byte
pad_bits  output  3  zero-pad count in the last byte (valid with byte_last)
flush_done  output  1  one-cycle pulse when a flush completes
busy  output  1  high whenever state != IDLE, bit count != 0, or a flush is pending

Behaviour:
- Reset (async, rst_n=0): state IDLE, accumulator=0, bit count cnt=0, armed=1, flush_pending=0. All outputs 0. Deassertion is synchronous to clk.
- Internal state: accumulator acc[16:0], cnt 0..17. Invariant: cnt<=7 whenever a code is accepted, so cnt<=17 and overflow is impossible.
- flush is latched into flush_pending on any cycle it is high, in any state.
- armed: cleared on accept; set on any cycle where code_valid=0. This is required because the coder holds valid_out high for 2 cycles after load; a code is accepted only once per low→high valid cycle.
- FSM states: IDLE, ACCEPT, EMIT, FLUSH.
- IDLE: evaluates one transition per cycle, with this priority:
  - cnt>=8 → EMIT.
  - Else flush_pending and cnt>0 → FLUSH.
  - Else flush_pending and cnt==0 → flush_done=1 for one cycle, flush_pending cleared, stay in IDLE.
  - Else code_valid and armed → ACCEPT.
  - A flush requested while a code is waiting applies only to bits already accepted; the waiting code is accepted afterwards.
- ACCEPT (exactly 1 cycle):
  - code_load=1 (registered, high only in this cycle).
  - acc <= (acc<<L) | code_in[L-1:0]; cnt <= cnt+L, where L=code_len clamped to MAX_CODE_LEN.
  - L=0 acknowledges with no bits added.
  - armed<=0; next state IDLE.
  - code_load is guaranteed low for at least 1 cycle before the next pulse, so the coder's edge detector always sees a rising edge.
- EMIT:
  - byte_valid=1, byte_out=acc[cnt-1 -: 8], byte_last=0.
  - Outputs stay stable while byte_ready=0.
  - On byte_valid&&byte_ready: cnt<=cnt-8. If new cnt>=8, stay in EMIT with the next byte on the following cycle; else return to IDLE.
  - Maximum 2 consecutive bytes per code.
- FLUSH:
  - byte_valid=1, byte_last=1, byte_out={acc[cnt-1:0], (8-cnt) zeros}, pad_bits=8-cnt.
  - On handshake: cnt<=0, acc<=0, flush_pending<=0, flush_done=1 for one cycle, next state IDLE.
- byte_ready is ignored when byte_valid=0. byte_valid deasserts in the cycle after the final handshake.
- No code is accepted while in EMIT or FLUSH. Backpressure therefore stalls the coder, because code_load is withheld.
- Throughput: at best 1 code per 2 cycles (IDLE→ACCEPT) when no bytes are pending.
- Reset mid-operation: outputs drop to 0 asynchronously and any partial byte is discarded. A coder still holding valid is re-accepted after reset (armed=1).

Test Plan:
- Two codes: 3'b101 (len 3), then 5'b11001 (len 5) → one byte 0xB9, byte_last=0. Exactly 2 code_load pulses; cnt returns to 0.
- Code 10'h3FF (len 10) → byte 0xFF with 2 bits residual. Then 6'b000000 (len 6) → byte 0xC0.
- Code 3'b101 then a flush pulse → byte 0xA0 with byte_last=1, pad_bits=5, then flush_done pulse. A flush with cnt==0 → flush_done only, no byte.
- Hold byte_ready=0 for 5 cycles during EMIT → byte_out/byte_valid stable, no code_load while code_valid=1. Release → byte accepted, then next code accepted.
- Hold code_valid=1 for 4 consecutive cycles → exactly one code_load. Drop for 1 cycle then raise → second code_load.
- Assert rst_n=0 mid-EMIT → byte_valid, code_load, busy all 0 immediately. After release, the first byte reflects only post-reset codes.

Source files
------------

// File: rtl/huffman_packer_if.sv
// Bus bundle for the Huffman packer: the code channel from the coder and the
// byte channel to the downstream consumer.
interface huffman_packer_if #(
  parameter int MAX_CODE_LEN = 10,
  parameter int LEN_W        = 4
);
  // Code channel (coder -> packer, acknowledge back to the coder's load input)
  logic [MAX_CODE_LEN-1:0] code_in;
  logic [LEN_W-1:0]        code_len;
  logic                    code_valid;
  logic                    code_load;

  // Byte channel (packer -> downstream)
  logic [7:0]              byte_out;
  logic                    byte_valid;
  logic                    byte_ready;
  logic                    byte_last;
  logic [2:0]              pad_bits;

  // Producer / consumer side: drives codes and byte_ready
  modport master (
    output code_in, code_len, code_valid, byte_ready,
    input  code_load, byte_out, byte_valid, byte_last, pad_bits
  );

  // Packer side
  modport slave (
    input  code_in, code_len, code_valid, byte_ready,
    output code_load, byte_out, byte_valid, byte_last, pad_bits
  );
endinterface

// File: rtl/huffman_packer.sv
// Huffman bitstream packer: appends variable-length codes MSB-first into an
// accumulator and emits the stream as bytes; a flush zero-pads the final
// partial byte and marks it with byte_last.
module huffman_packer #(
  parameter int MAX_CODE_LEN = 10,
  parameter int LEN_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  huffman_packer_if.slave  bus,
  input  logic             flush,
  output logic             flush_done,
  output logic             busy
);

  // Accumulator must hold up to 7 leftover bits plus one widest code.
  localparam int ACC_W = MAX_CODE_LEN + 7;
  localparam int CNT_W = $clog2(ACC_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    armed_q, armed_d;
  logic                    flush_pending_q, flush_pending_d;
  logic                    flush_done_q, flush_done_d;

  logic [LEN_W-1:0]        len_clamped;
  logic [MAX_CODE_LEN-1:0] code_masked;
  logic [CNT_W-1:0]        cnt_minus8;
  logic [CNT_W-1:0]        pad_count;
  logic                    pending_clear;
  logic [7:0]              emit_byte;
  logic [7:0]              flush_byte;

  // Clamp over-long lengths and strip any bits above the code length, so
  // garbage in the unused upper bits of code_in never reaches the stream.
  always_comb begin
    if (bus.code_len > LEN_W'(MAX_CODE_LEN)) begin
      len_clamped = LEN_W'(MAX_CODE_LEN);
    end else begin
      len_clamped = bus.code_len;
    end
    code_masked = bus.code_in & ~({MAX_CODE_LEN{1'b1}} << len_clamped);
  end

  // Byte extraction: the oldest pending bit sits at acc[cnt-1].
  always_comb begin
    cnt_minus8 = cnt_q - CNT_W'(8);
    pad_count  = CNT_W'(8) - cnt_q;
    emit_byte  = 8'(acc_q >> cnt_minus8);
    flush_byte = 8'(acc_q << pad_count);
  end

  // Next-state logic for the packer FSM, accumulator and handshake flags.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    armed_d       = armed_q | ~bus.code_valid;
    pending_clear = 1'b0;
    flush_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cnt_q >= CNT_W'(8)) begin
          state_d = S_EMIT;
        end else if (flush_pending_q && (cnt_q != '0)) begin
          state_d = S_FLUSH;
        end else if (flush_pending_q) begin
          // Nothing buffered: the flush completes without a byte.
          pending_clear = 1'b1;
          flush_done_d  = 1'b1;
        end else if (bus.code_valid && armed_q) begin
          state_d = S_ACCEPT;
        end
      end

      S_ACCEPT: begin
        acc_d   = (acc_q << len_clamped) | ACC_W'(code_masked);
        cnt_d   = cnt_q + CNT_W'(len_clamped);
        armed_d = 1'b0;
        state_d = S_IDLE;
      end

      S_EMIT: begin
        if (bus.byte_ready) begin
          cnt_d   = cnt_minus8;
          state_d = (cnt_minus8 >= CNT_W'(8)) ? S_EMIT : S_IDLE;
        end
      end

      S_FLUSH: begin
        if (bus.byte_ready) begin
          acc_d         = '0;
          cnt_d         = '0;
          pending_clear = 1'b1;
          flush_done_d  = 1'b1;
          state_d       = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A flush request arriving on the completing cycle stays pending.
    flush_pending_d = (flush_pending_q & ~pending_clear) | flush;
  end

  // State registers; reset returns to an empty, armed packer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      acc_q           <= '0;
      cnt_q           <= '0;
      armed_q         <= 1'b1;
      flush_pending_q <= 1'b0;
      flush_done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q         <= state_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      armed_q         <= armed_d;
      flush_pending_q <= flush_pending_d;
      flush_done_q    <= flush_done_d;
    end
  end

  // Outputs decode directly from registered state, so reset clears them at once.
  always_comb begin
    bus.code_load  = (state_q == S_ACCEPT);
    bus.byte_valid = (state_q == S_EMIT) || (state_q == S_FLUSH);
    bus.byte_last  = (state_q == S_FLUSH);
    bus.pad_bits   = (state_q == S_FLUSH) ? pad_count[2:0] : 3'd0;
    case (state_q)
      S_EMIT:  bus.byte_out = emit_byte;
      S_FLUSH: bus.byte_out = flush_byte;
      default: bus.byte_out = 8'h00;
    endcase
    flush_done = flush_done_q;
    busy       = (state_q != S_IDLE) || (cnt_q != '0) || flush_pending_q;
  end

endmodule

// File: tb/tb_huffman_packer.sv
// Self-checking bench for huffman_packer: directed vector table, hand-written
// corner sequences, and randomized code streams against a bit-queue model.
module tb_huffman_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic flush_done;
  logic busy;

  always #5 clk = ~clk;

  huffman_packer_if #(.MAX_CODE_LEN(10), .LEN_W(4)) hp_if ();

  huffman_packer #(.MAX_CODE_LEN(10), .LEN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (hp_if.slave),
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic [2:0] pad;
  } byte_rec_t;

  typedef struct {
    int         ncodes;
    logic [9:0] c0;
    logic [3:0] l0;
    logic [9:0] c1;
    logic [3:0] l1;
    bit         do_flush;
    int         nbytes;
    logic [7:0] b0;
    logic [7:0] b1;
    bit         last_fin;
    logic [2:0] pad;
  } vec_t;

  int        vectors = 0;
  int        miscompares = 0;
  byte_rec_t cap_q[$];
  int        load_cnt = 0;
  int        fd_cnt = 0;
  int        rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: record accepted bytes, load pulses and flush_done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (hp_if.byte_valid && hp_if.byte_ready)
          cap_q.push_back('{b: hp_if.byte_out, last: hp_if.byte_last, pad: hp_if.pad_bits});
        if (hp_if.code_load) load_cnt++;
        if (flush_done) fd_cnt++;
      end
    end
  end

  // Downstream ready driver, updated just after each rising edge.
  initial begin
    hp_if.byte_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       hp_if.byte_ready = 1'b1;
        1:       hp_if.byte_ready = ($urandom_range(0, 3) != 0);
        default: hp_if.byte_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Coder model: valid stays high until load, then two more cycles, then low.
  task automatic send_code(input logic [9:0] c, input logic [3:0] l);
    int n;
    bit seen;
    @(posedge clk);
    #1;
    hp_if.code_in    = c;
    hp_if.code_len   = l;
    hp_if.code_valid = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      if (hp_if.code_load) seen = 1'b1;
      n++;
    end
    if (!seen) timeout_fail("code_load");
    repeat (3) @(posedge clk);
    #1;
    hp_if.code_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout_fail(name);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_obs();
    cap_q.delete();
    load_cnt = 0;
    fd_cnt = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  vec_t      vt[8];
  bit        bits_q[$];
  byte_rec_t exp_q[$];

  initial begin
    hp_if.code_in    = '0;
    hp_if.code_len   = '0;
    hp_if.code_valid = 1'b0;

    // ---------------- reset state ----------------
    #12;
    check("reset_byte_valid", 32'(hp_if.byte_valid), 0);
    check("reset_code_load",  32'(hp_if.code_load), 0);
    check("reset_outs", 32'({hp_if.byte_out, hp_if.byte_last, hp_if.pad_bits, flush_done, busy}), 0);
    apply_reset();
    check("post_reset_busy", 32'(busy), 0);

    // ---------------- directed table ----------------
    vt[0] = '{2, 10'h005, 4'd3,  10'h019, 4'd5, 1'b0, 1, 8'hB9, 8'h00, 1'b0, 3'd0};
    vt[1] = '{2, 10'h3FF, 4'd10, 10'h000, 4'd6, 1'b0, 2, 8'hFF, 8'hC0, 1'b0, 3'd0};
    vt[2] = '{1, 10'h005, 4'd3,  10'h000, 4'd0, 1'b1, 1, 8'hA0, 8'h00, 1'b1, 3'd5};
    vt[3] = '{0, 10'h000, 4'd0,  10'h000, 4'd0, 1'b1, 0, 8'h00, 8'h00, 1'b0, 3'd0};
    vt[4] = '{1, 10'h3FF, 4'd10, 10'h000, 4'd0, 1'b1, 2, 8'hFF, 8'hC0, 1'b1, 3'd6};
    vt[5] = '{2, 10'h055, 4'd0,  10'h001, 4'd1, 1'b1, 1, 8'h80, 8'h00, 1'b1, 3'd7};
    vt[6] = '{2, 10'h2AA, 4'd15, 10'h03F, 4'd6, 1'b0, 2, 8'hAA, 8'hBF, 1'b0, 3'd0};
    vt[7] = '{2, 10'h3F5, 4'd3,  10'h3F9, 4'd5, 1'b0, 1, 8'hB9, 8'h00, 1'b0, 3'd0};

    rdy_mode = 0;
    for (int v = 0; v < 8; v++) begin
      clear_obs();
      if (vt[v].ncodes >= 1) send_code(vt[v].c0, vt[v].l0);
      if (vt[v].ncodes >= 2) send_code(vt[v].c1, vt[v].l1);
      if (vt[v].do_flush) pulse_flush();
      wait_quiet($sformatf("vec%0d_quiet", v));
      check($sformatf("vec%0d_nbytes", v), 32'(cap_q.size()), 32'(vt[v].nbytes));
      for (int i = 0; i < vt[v].nbytes && i < cap_q.size(); i++) begin
        bit fin;
        fin = vt[v].last_fin && (i == vt[v].nbytes - 1);
        check($sformatf("vec%0d_byte%0d", v, i), 32'(cap_q[i].b), 32'((i == 0) ? vt[v].b0 : vt[v].b1));
        check($sformatf("vec%0d_last%0d", v, i), 32'({cap_q[i].last, cap_q[i].pad}),
              32'({fin, fin ? vt[v].pad : 3'd0}));
      end
      check($sformatf("vec%0d_loads", v), 32'(load_cnt), 32'(vt[v].ncodes));
      check($sformatf("vec%0d_flush_done", v), 32'(fd_cnt), 32'(vt[v].do_flush));
      check($sformatf("vec%0d_busy", v), 32'(busy), 0);
    end

    // ---------------- backpressure during EMIT ----------------
    clear_obs();
    rdy_mode = 2;
    send_code(10'h3FF, 4'd10);
    @(posedge clk);
    #1;
    hp_if.code_in    = 10'h000;
    hp_if.code_len   = 4'd6;
    hp_if.code_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d", k), 32'({hp_if.byte_valid, hp_if.byte_out, hp_if.code_load}),
            32'({1'b1, 8'hFF, 1'b0}));
    end
    check("stall_loads", 32'(load_cnt), 1);
    rdy_mode = 0;
    begin
      int n;
      n = 0;
      while (load_cnt < 2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (load_cnt < 2) timeout_fail("stall_release_load");
    end
    repeat (3) @(posedge clk);
    #1 hp_if.code_valid = 1'b0;
    wait_quiet("stall_quiet");
    check("stall_nbytes", 32'(cap_q.size()), 2);
    if (cap_q.size() == 2) begin
      check("stall_b0", 32'(cap_q[0]), 32'(byte_rec_t'({8'hFF, 1'b0, 3'd0})));
      check("stall_b1", 32'(cap_q[1]), 32'(byte_rec_t'({8'hC0, 1'b0, 3'd0})));
    end

    // ---------------- valid held high: one load per rising edge ----------------
    clear_obs();
    @(posedge clk);
    #1;
    hp_if.code_in    = 10'h001;
    hp_if.code_len   = 4'd1;
    hp_if.code_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("hold_one_load", 32'(load_cnt), 1);
    hp_if.code_valid = 1'b0;
    @(posedge clk);
    #1 hp_if.code_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    hp_if.code_valid = 1'b0;
    check("hold_second_load", 32'(load_cnt), 2);
    pulse_flush();
    wait_quiet("hold_quiet");
    check("hold_nbytes", 32'(cap_q.size()), 1);
    if (cap_q.size() == 1)
      check("hold_byte", 32'(cap_q[0]), 32'(byte_rec_t'({8'hC0, 1'b1, 3'd6})));

    // ---------------- reset in the middle of EMIT ----------------
    clear_obs();
    rdy_mode = 2;
    send_code(10'h3FF, 4'd10);
    @(negedge clk);
    check("pre_reset_emit", 32'(hp_if.byte_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_outs", 32'({hp_if.byte_valid, hp_if.code_load, busy}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    clear_obs();
    send_code(10'h005, 4'd3);
    send_code(10'h019, 4'd5);
    wait_quiet("postrst_quiet");
    check("postrst_nbytes", 32'(cap_q.size()), 1);
    if (cap_q.size() == 1)
      check("postrst_byte", 32'(cap_q[0]), 32'(byte_rec_t'({8'hB9, 1'b0, 3'd0})));

    // ---------------- randomized streams vs bit-queue model ----------------
    rdy_mode = 1;
    for (int t = 0; t < 25; t++) begin
      int ncodes;
      clear_obs();
      bits_q.delete();
      exp_q.delete();
      ncodes = $urandom_range(1, 10);
      for (int j = 0; j < ncodes; j++) begin
        logic [9:0] c;
        logic [3:0] l;
        int eff;
        c = 10'($urandom);
        l = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
        eff = (l > 10) ? 10 : int'(l);
        send_code(c, l);
        for (int k = eff - 1; k >= 0; k--) bits_q.push_back(c[k]);
      end
      pulse_flush();
      wait_quiet($sformatf("rand%0d_quiet", t));
      // Model: chunk the bitstream into bytes, zero-pad the tail.
      while (bits_q.size() > 0) begin
        byte_rec_t r;
        int nb;
        nb = (bits_q.size() >= 8) ? 8 : bits_q.size();
        r.b = 8'h00;
        for (int k = 0; k < nb; k++) r.b[7-k] = bits_q.pop_front();
        r.last = (nb < 8);
        r.pad  = (nb < 8) ? 3'(8 - nb) : 3'd0;
        exp_q.push_back(r);
      end
      check($sformatf("rand%0d_nbytes", t), 32'(cap_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
        check($sformatf("rand%0d_byte%0d", t, i), 32'(cap_q[i]), 32'(exp_q[i]));
      check($sformatf("rand%0d_loads", t), 32'(load_cnt), 32'(ncodes));
      check($sformatf("rand%0d_flush_done", t), 32'(fd_cnt), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
